// File: rtl/register_bank.sv
// Architectural register file of the 5-stage MIPS core: two bypassed combinational
// read ports, one write-back port and a handshaked dump sequencer for the debug unit.
module register_bank #(
    parameter int NB_DATA        = 32,
    parameter int NB_REG_ADDRESS = 5,
    parameter int N_REGISTERS    = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_write_enable,
    input  logic [NB_REG_ADDRESS-1:0] i_address_write,
    input  logic [NB_DATA-1:0]        i_data_write,
    input  logic [NB_REG_ADDRESS-1:0] i_address_read_rs,
    input  logic [NB_REG_ADDRESS-1:0] i_address_read_rt,
    output logic [NB_DATA-1:0]        o_data_rs,
    output logic [NB_DATA-1:0]        o_data_rt,
    input  logic                      i_dump_start,
    input  logic                      i_dump_ready,
    output logic                      o_dump_valid,
    output logic [NB_DATA-1:0]        o_dump_data,
    output logic [NB_REG_ADDRESS-1:0] o_dump_address,
    output logic                      o_dump_busy,
    output logic                      o_dump_done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } dump_state_t;

    localparam logic [NB_REG_ADDRESS-1:0] LAST_INDEX = NB_REG_ADDRESS'(N_REGISTERS - 1);

    logic [NB_DATA-1:0]        registers [N_REGISTERS];
    logic [NB_DATA-1:0]        load_word;
    logic [NB_REG_ADDRESS-1:0] dump_index;
    dump_state_t               dump_state;

    // Register 0 is never written, so it stays at its reset value of zero
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGISTERS; i++) begin
                registers[i] <= '0;
            end
        end else if (i_write_enable && (i_address_write != '0)) begin
            registers[i_address_write] <= i_data_write;
        end
    end

    always_comb begin
        o_data_rs = registers[i_address_read_rs];
        if (i_address_read_rs == '0) begin
            o_data_rs = '0;
        end else if (i_write_enable && (i_address_write == i_address_read_rs)) begin
            o_data_rs = i_data_write;
        end
    end

    always_comb begin
        o_data_rt = registers[i_address_read_rt];
        if (i_address_read_rt == '0) begin
            o_data_rt = '0;
        end else if (i_write_enable && (i_address_write == i_address_read_rt)) begin
            o_data_rt = i_data_write;
        end
    end

    // The dump port sees the same bypassed view as the decode ports
    always_comb begin
        load_word = registers[dump_index];
        if (dump_index == '0) begin
            load_word = '0;
        end else if (i_write_enable && (i_address_write == dump_index)) begin
            load_word = i_data_write;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            dump_state     <= IDLE;
            dump_index     <= '0;
            o_dump_valid   <= 1'b0;
            o_dump_busy    <= 1'b0;
            o_dump_done    <= 1'b0;
            o_dump_data    <= '0;
            o_dump_address <= '0;
        end else begin
            case (dump_state)
                IDLE: begin
                    o_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        dump_index  <= '0;
                        o_dump_busy <= 1'b1;
                        dump_state  <= LOAD;
                    end
                end
                LOAD: begin
                    o_dump_data    <= load_word;
                    o_dump_address <= dump_index;
                    o_dump_valid   <= 1'b1;
                    dump_state     <= SEND;
                end
                SEND: begin
                    // Word and address stay frozen until the debug unit accepts them
                    if (i_dump_ready) begin
                        o_dump_valid <= 1'b0;
                        if (dump_index == LAST_INDEX) begin
                            o_dump_busy <= 1'b0;
                            o_dump_done <= 1'b1;
                            dump_state  <= DONE;
                        end else begin
                            dump_index <= dump_index + 1'b1;
                            dump_state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    o_dump_done <= 1'b0;
                    dump_state  <= IDLE;
                end
                default: begin
                    dump_state <= IDLE;
                end
            endcase
        end
    end

endmodule
